// File: rtl/vram_console_writer.sv
// Byte-stream console writer for the single-port text video RAM.
// Tracks a cursor, writes printable bytes, and handles clear, wrap and scroll-up.
module vram_console_writer #(
    parameter int unsigned COLS   = 80,
    parameter int unsigned ROWS   = 25,
    parameter int unsigned ADDR_W = 12,
    parameter logic [7:0]  BLANK  = 8'h20
) (
    input  logic              vclk,
    input  logic              rst_n,
    input  logic [7:0]        char_in,
    input  logic              char_valid,
    output logic              char_ready,
    output logic              busy,
    output logic [ADDR_W-1:0] vram_addr,
    output logic [7:0]        vram_din,
    output logic              vram_we,
    input  logic [7:0]        vram_dout,
    output logic [6:0]        cursor_x,
    output logic [4:0]        cursor_y
);
    localparam int unsigned CELLS         = COLS * ROWS;
    localparam int unsigned LAST_ROW_BASE = (ROWS - 1) * COLS;
    localparam int unsigned SCROLL_LAST   = LAST_ROW_BASE - 1;

    localparam logic [7:0] CODE_CR = 8'h0D;
    localparam logic [7:0] CODE_LF = 8'h0A;
    localparam logic [7:0] CODE_BS = 8'h08;
    localparam logic [7:0] CODE_FF = 8'h0C;

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_PUT,
        S_CLEAR,
        S_SCRL_RD,
        S_SCRL_WR,
        S_SCRL_BLANK
    } state_t;

    state_t            state, state_d;
    logic [ADDR_W-1:0] cnt, cnt_d;
    logic [6:0]        cur_x, cur_x_d;
    logic [4:0]        cur_y, cur_y_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        din_q, din_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] pos;

    // Port outputs describe the action of the current state; registers are loaded on entry.
    always_ff @(posedge vclk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_INIT;
            cnt    <= '0;
            cur_x  <= '0;
            cur_y  <= '0;
            addr_q <= '0;
            din_q  <= '0;
            we_q   <= 1'b0;
        end else begin
            state  <= state_d;
            cnt    <= cnt_d;
            cur_x  <= cur_x_d;
            cur_y  <= cur_y_d;
            addr_q <= addr_d;
            din_q  <= din_d;
            we_q   <= we_d;
        end
    end

    assign pos = ADDR_W'(cur_y) * ADDR_W'(COLS) + ADDR_W'(cur_x);

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        cur_x_d = cur_x;
        cur_y_d = cur_y;
        addr_d  = '0;
        din_d   = '0;
        we_d    = 1'b0;
        case (state)
            S_INIT: begin
                state_d = S_CLEAR;
                cnt_d   = '0;
                din_d   = BLANK;
                we_d    = 1'b1;
            end
            S_IDLE: begin
                if (char_valid) begin
                    case (char_in)
                        CODE_CR: cur_x_d = '0;
                        CODE_LF: begin
                            if (cur_y < 5'(ROWS - 1)) begin
                                cur_y_d = cur_y + 5'd1;
                            end else begin
                                state_d = S_SCRL_RD;
                                cnt_d   = '0;
                                addr_d  = ADDR_W'(COLS);
                            end
                        end
                        CODE_BS: begin
                            if (cur_x != 7'd0) cur_x_d = cur_x - 7'd1;
                        end
                        CODE_FF: begin
                            state_d = S_CLEAR;
                            cnt_d   = '0;
                            din_d   = BLANK;
                            we_d    = 1'b1;
                        end
                        default: begin
                            state_d = S_PUT;
                            addr_d  = pos;
                            din_d   = char_in;
                            we_d    = 1'b1;
                        end
                    endcase
                end
            end
            S_PUT: begin
                state_d = S_IDLE;
                if (cur_x < 7'(COLS - 1)) begin
                    cur_x_d = cur_x + 7'd1;
                end else begin
                    cur_x_d = '0;
                    if (cur_y < 5'(ROWS - 1)) begin
                        cur_y_d = cur_y + 5'd1;
                    end else begin
                        state_d = S_SCRL_RD;
                        cnt_d   = '0;
                        addr_d  = ADDR_W'(COLS);
                    end
                end
            end
            S_CLEAR: begin
                if (cnt == ADDR_W'(CELLS - 1)) begin
                    state_d = S_IDLE;
                    cur_x_d = '0;
                    cur_y_d = '0;
                end else begin
                    cnt_d  = cnt + ADDR_W'(1);
                    addr_d = cnt + ADDR_W'(1);
                    din_d  = BLANK;
                    we_d   = 1'b1;
                end
            end
            S_SCRL_RD: begin
                state_d = S_SCRL_WR;
                addr_d  = cnt;
                we_d    = 1'b1;
            end
            S_SCRL_WR: begin
                if (cnt == ADDR_W'(SCROLL_LAST)) begin
                    state_d = S_SCRL_BLANK;
                    cnt_d   = ADDR_W'(LAST_ROW_BASE);
                    addr_d  = ADDR_W'(LAST_ROW_BASE);
                    din_d   = BLANK;
                    we_d    = 1'b1;
                end else begin
                    state_d = S_SCRL_RD;
                    cnt_d   = cnt + ADDR_W'(1);
                    addr_d  = cnt + ADDR_W'(1 + COLS);
                end
            end
            S_SCRL_BLANK: begin
                if (cnt == ADDR_W'(CELLS - 1)) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d  = cnt + ADDR_W'(1);
                    addr_d = cnt + ADDR_W'(1);
                    din_d  = BLANK;
                    we_d   = 1'b1;
                end
            end
            default: state_d = S_INIT;
        endcase
    end

    // Scroll copies the read data straight through in the cycle it arrives.
    assign vram_din   = (state == S_SCRL_WR) ? vram_dout : din_q;
    assign vram_addr  = addr_q;
    assign vram_we    = we_q;
    assign cursor_x   = cur_x;
    assign cursor_y   = cur_y;
    assign char_ready = (state == S_IDLE);
    assign busy       = (state == S_CLEAR) || (state == S_SCRL_RD) ||
                        (state == S_SCRL_WR) || (state == S_SCRL_BLANK);

endmodule
